// File: rtl/branch_target_resolve_pipe.sv
// branch_target_resolve_pipe
//   Registered branch/jump target resolver sitting after rename. For each
//   accepted instruction it:
//     - emits the sequential successor pc+PCINC to the ROB (seq_*),
//     - resolves JAL / conditional-branch targets and raises a held fetch
//       redirect (misdirect/target) when the prediction was wrong, released
//       by redirect_ack,
//     - allocates the lowest free branch tag for conditional branches
//       (br_tag_*), released later through br_free,
//     - executes LUI/AUIPC and offers the result to the CDB through a
//       one-entry req/grant skid slot (cdb_*).
//   flush clears all pending control state; reset is asynchronous.
// Ports
//   clk, reset                    clock, async active-high reset
//   valid_in / ready_out          rename handshake
//   pc, imm_ext, predicted_pc     instruction operands and fetch prediction
//   rob_idx, op                   ROB entry, opcode class (0..4)
//   redirect_en                   allows a redirect for this instruction
//   misdirect, target, redirect_ack  held fetch redirect and its ack
//   seq_pc, seq_valid, seq_rob    sequential PC result for the ROB
//   br_tag_valid, br_tag          tag allocated for a conditional branch
//   br_free, br_free_tag          tag release
//   flush                         pipeline flush from commit
//   cdb_req, cdb_data, cdb_rob, cdb_grant  U-type result to CDB arbiter
module branch_target_resolve_pipe #(
  parameter int WIDTH = 32,
  parameter int ROBW  = 3,
  parameter int DEPTH = 4,
  parameter int PCINC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [WIDTH-1:0]         pc,
  input  logic [WIDTH-1:0]         imm_ext,
  input  logic [WIDTH-1:0]         predicted_pc,
  input  logic [ROBW-1:0]          rob_idx,
  input  logic [2:0]               op,
  input  logic                     redirect_en,
  output logic                     misdirect,
  output logic [WIDTH-1:0]         target,
  input  logic                     redirect_ack,
  output logic [WIDTH-1:0]         seq_pc,
  output logic                     seq_valid,
  output logic [ROBW-1:0]          seq_rob,
  output logic                     br_tag_valid,
  output logic [$clog2(DEPTH)-1:0] br_tag,
  input  logic                     br_free,
  input  logic [$clog2(DEPTH)-1:0] br_free_tag,
  input  logic                     flush,
  output logic                     cdb_req,
  output logic [WIDTH-1:0]         cdb_data,
  output logic [ROBW-1:0]          cdb_rob,
  input  logic                     cdb_grant
);

  localparam int TW = $clog2(DEPTH);
  localparam logic [2:0] OP_BR    = 3'd1;
  localparam logic [2:0] OP_JAL   = 3'd2;
  localparam logic [2:0] OP_LUI   = 3'd3;
  localparam logic [2:0] OP_AUIPC = 3'd4;
  localparam logic signed [WIDTH-1:0] PCINC_S = WIDTH'(PCINC);

  typedef enum logic {IDLE, REDIR} state_t;

  // Two's-complement add; overflow wraps silently.
  function automatic logic signed [WIDTH-1:0] add_wrap(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    return a + b;
  endfunction

  // Lowest-index clear bit of the busy map; only meaningful when not full.
  function automatic logic [TW-1:0] lowest_free(input logic [DEPTH-1:0] busy);
    logic [TW-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) idx = TW'(i);
    end
    return idx;
  endfunction

  logic signed [WIDTH-1:0] pc_s, imm_s, pred_s, addr, seq_pc_d;
  logic                    is_br, is_jal, is_u, tags_full;
  logic                    accept, take, take_redirect;
  logic [TW-1:0]           free_idx;
  logic [DEPTH-1:0]        busy_p1, busy_d;
  state_t                  state_p1, state_d;

  logic                    vld_p1, tag_vld_p1, cdb_vld_p1;
  logic signed [WIDTH-1:0] seq_pc_p1, target_p1, cdb_data_p1;
  logic [ROBW-1:0]         seq_rob_p1, cdb_rob_p1;
  logic [TW-1:0]           tag_p1;

  assign pc_s     = pc;
  assign imm_s    = imm_ext;
  assign pred_s   = predicted_pc;
  assign addr     = add_wrap(pc_s, imm_s);
  assign seq_pc_d = add_wrap(pc_s, PCINC_S);

  assign is_br     = (op == OP_BR);
  assign is_jal    = (op == OP_JAL);
  assign is_u      = (op == OP_LUI) || (op == OP_AUIPC);
  assign tags_full = &busy_p1;
  assign free_idx  = lowest_free(busy_p1);

  // A U-type may enter while the slot is full only if the slot drains now.
  assign ready_out = (state_p1 == IDLE)
                   && !(cdb_vld_p1 && !cdb_grant && is_u)
                   && !(is_br && tags_full);
  assign accept        = valid_in && ready_out;
  assign take          = accept && !flush;
  assign take_redirect = accept && (is_br || is_jal) && redirect_en && (addr != pred_s);

  always_comb begin
    state_d = state_p1;
    case (state_p1)
      IDLE:    if (take_redirect) state_d = REDIR;
      REDIR:   if (redirect_ack)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_p1 <= IDLE;
    else       state_p1 <= state_d;
  end

  // Allocation picks from the pre-free map, so a tag freed this cycle is
  // only reusable next cycle.
  always_comb begin
    busy_d = busy_p1;
    if (br_free)      busy_d[br_free_tag] = 1'b0;
    if (take && is_br) busy_d[free_idx]   = 1'b1;
    if (flush)        busy_d = '0;
  end

  // ---- stage p0 -> p1: registered results ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      tag_vld_p1  <= 1'b0;
      cdb_vld_p1  <= 1'b0;
      busy_p1     <= '0;
      seq_pc_p1   <= '0;
      seq_rob_p1  <= '0;
      tag_p1      <= '0;
      target_p1   <= '0;
      cdb_data_p1 <= '0;
      cdb_rob_p1  <= '0;
    end else begin
      vld_p1     <= take;
      tag_vld_p1 <= take && is_br;
      busy_p1    <= busy_d;
      if (take) begin
        seq_pc_p1  <= seq_pc_d;
        seq_rob_p1 <= rob_idx;
      end
      if (take && is_br) tag_p1 <= free_idx;
      if (take_redirect && !flush) target_p1 <= addr;
      if (flush) begin
        cdb_vld_p1 <= 1'b0;
      end else if (take && is_u) begin
        cdb_vld_p1  <= 1'b1;
        cdb_data_p1 <= (op == OP_LUI) ? imm_s : addr;
        cdb_rob_p1  <= rob_idx;
      end else if (cdb_grant) begin
        cdb_vld_p1 <= 1'b0;
      end
    end
  end

  assign misdirect    = (state_p1 == REDIR);
  assign target       = target_p1;
  assign seq_valid    = vld_p1;
  assign seq_pc       = seq_pc_p1;
  assign seq_rob      = seq_rob_p1;
  assign br_tag_valid = tag_vld_p1;
  assign br_tag       = tag_p1;
  assign cdb_req      = cdb_vld_p1;
  assign cdb_data     = cdb_data_p1;
  assign cdb_rob      = cdb_rob_p1;

endmodule

// File: tb/tb_branch_target_resolve_pipe.sv
// Testbench for branch_target_resolve_pipe: directed scenarios followed by
// randomized traffic. A driver applies one instruction per cycle and a
// behavioural model queues expected results; monitors pop and compare when
// the DUT presents seq / tag / redirect / CDB transfers.
module tb_branch_target_resolve_pipe;
  localparam int WIDTH = 32;
  localparam int ROBW  = 3;
  localparam int DEPTH = 4;
  localparam int PCINC = 1;
  localparam int TW    = 2;

  logic             clk = 1'b0;
  logic             reset, valid_in, ready_out, redirect_en, misdirect, redirect_ack;
  logic [WIDTH-1:0] pc, imm_ext, predicted_pc, target, seq_pc, cdb_data;
  logic [ROBW-1:0]  rob_idx, seq_rob, cdb_rob;
  logic [2:0]       op;
  logic             seq_valid, br_tag_valid, br_free, flush, cdb_req, cdb_grant;
  logic [TW-1:0]    br_tag, br_free_tag;

  branch_target_resolve_pipe #(.WIDTH(WIDTH), .ROBW(ROBW), .DEPTH(DEPTH), .PCINC(PCINC)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
    .pc(pc), .imm_ext(imm_ext), .predicted_pc(predicted_pc), .rob_idx(rob_idx),
    .op(op), .redirect_en(redirect_en), .misdirect(misdirect), .target(target),
    .redirect_ack(redirect_ack), .seq_pc(seq_pc), .seq_valid(seq_valid),
    .seq_rob(seq_rob), .br_tag_valid(br_tag_valid), .br_tag(br_tag),
    .br_free(br_free), .br_free_tag(br_free_tag), .flush(flush),
    .cdb_req(cdb_req), .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_grant(cdb_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] v;
    logic [ROBW-1:0]  rob;
  } ent_t;

  ent_t          seq_q[$];
  ent_t          cdb_q[$];
  logic [TW-1:0] tag_q[$];
  logic [WIDTH-1:0] tgt_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: what the block should be showing after the next edge.
  bit m_redir, m_cdb, m_seq_v, m_tag_v;
  bit m_busy[DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_redir = 0; m_cdb = 0; m_seq_v = 0; m_tag_v = 0;
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    seq_q.delete(); cdb_q.delete(); tag_q.delete(); tgt_q.delete();
  endtask

  // One clock of stimulus: drive at negedge, check visible state, advance model.
  task automatic cycle(input int v, input int o, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] pr, input int rb, input int ren, input int ak,
                       input int gr, input int bf, input int bft, input int fl);
    bit full, isu, exp_ready, acc;
    logic [31:0] a;
    int idx;
    ent_t e;
    @(negedge clk);
    valid_in = (v != 0); op = 3'(o); pc = p; imm_ext = im; predicted_pc = pr;
    rob_idx = 3'(rb); redirect_en = (ren != 0); redirect_ack = (ak != 0);
    cdb_grant = (gr != 0); br_free = (bf != 0); br_free_tag = 2'(bft); flush = (fl != 0);
    #1;
    full = 1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) full = 0;
    isu = (o == 3) || (o == 4);
    exp_ready = !m_redir && !(m_cdb && gr == 0 && isu) && !(o == 1 && full);
    chk("ready_out", 64'(ready_out), 64'(exp_ready));
    chk("misdirect", 64'(misdirect), 64'(m_redir));
    chk("cdb_req", 64'(cdb_req), 64'(m_cdb));
    chk("seq_valid", 64'(seq_valid), 64'(m_seq_v));
    chk("br_tag_valid", 64'(br_tag_valid), 64'(m_tag_v));
    acc = (v != 0) && exp_ready;
    a = p + im;
    idx = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[i] && idx < 0) idx = i;
    if (fl != 0) begin
      if (m_cdb && gr == 0) void'(cdb_q.pop_back());
      m_redir = 0; m_cdb = 0; m_seq_v = 0; m_tag_v = 0;
      for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
    end else begin
      m_seq_v = acc;
      if (acc) begin
        e.v = p + 32'(PCINC); e.rob = 3'(rb);
        seq_q.push_back(e);
      end
      m_tag_v = acc && (o == 1);
      if (bf != 0) m_busy[bft] = 0;
      if (acc && o == 1) begin
        m_busy[idx] = 1;
        tag_q.push_back(2'(idx));
      end
      if (acc && isu) begin
        e.v = (o == 3) ? im : a; e.rob = 3'(rb);
        cdb_q.push_back(e);
        m_cdb = 1;
      end else if (gr != 0) begin
        m_cdb = 0;
      end
      if (m_redir) begin
        if (ak != 0) m_redir = 0;
      end else if (acc && (o == 1 || o == 2) && ren != 0 && a != pr) begin
        m_redir = 1;
        tgt_q.push_back(a);
      end
    end
  endtask

  task automatic idle(input int ak, input int gr);
    cycle(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, ak, gr, 0, 0, 0);
  endtask

  // Monitor: registered results just after each rising edge.
  initial begin
    ent_t e;
    logic prev_mis;
    logic [WIDTH-1:0] cur_tgt;
    logic [TW-1:0] t;
    prev_mis = 1'b0;
    cur_tgt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (seq_valid) begin
        chk("seq_expected", 64'(seq_q.size() != 0), 64'd1);
        if (seq_q.size() != 0) begin
          e = seq_q.pop_front();
          chk("seq_pc", 64'(seq_pc), 64'(e.v));
          chk("seq_rob", 64'(seq_rob), 64'(e.rob));
        end
      end
      if (br_tag_valid) begin
        chk("tag_expected", 64'(tag_q.size() != 0), 64'd1);
        if (tag_q.size() != 0) begin
          t = tag_q.pop_front();
          chk("br_tag", 64'(br_tag), 64'(t));
        end
      end
      if (misdirect && !prev_mis) begin
        chk("redirect_expected", 64'(tgt_q.size() != 0), 64'd1);
        if (tgt_q.size() != 0) cur_tgt = tgt_q.pop_front();
        chk("target", 64'(target), 64'(cur_tgt));
      end else if (misdirect) begin
        chk("target_hold", 64'(target), 64'(cur_tgt));
      end
      prev_mis = misdirect;
    end
  end

  // Monitor: CDB transfers, sampled while grant is stable mid-cycle.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cdb_req && cdb_grant) begin
        chk("cdb_expected", 64'(cdb_q.size() != 0), 64'd1);
        if (cdb_q.size() != 0) begin
          e = cdb_q.pop_front();
          chk("cdb_data", 64'(cdb_data), 64'(e.v));
          chk("cdb_rob", 64'(cdb_rob), 64'(e.rob));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; valid_in = 1'b0; op = 3'd0; pc = '0; imm_ext = '0; predicted_pc = '0;
    rob_idx = '0; redirect_en = 1'b0; redirect_ack = 1'b0; cdb_grant = 1'b0;
    br_free = 1'b0; br_free_tag = '0; flush = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    #12;
    chk("rst_misdirect", 64'(misdirect), 64'd0);
    chk("rst_seq_valid", 64'(seq_valid), 64'd0);
    chk("rst_br_tag_valid", 64'(br_tag_valid), 64'd0);
    chk("rst_cdb_req", 64'(cdb_req), 64'd0);
    chk("rst_target", 64'(target), 64'd0);
    chk("rst_seq_pc", 64'(seq_pc), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Correctly predicted branch: tag 0, no redirect.
    cycle(1, 1, 32'h100, 32'h20, 32'h120, 1, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t1_br_tag", 64'(br_tag), 64'd0);
    chk("t1_seq_pc", 64'(seq_pc), 64'h101);
    chk("t1_misdirect", 64'(misdirect), 64'd0);

    // Mispredicted JAL: redirect held three cycles, then acknowledged.
    cycle(1, 2, 32'h100, 32'h40, 32'h101, 2, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t2_target", 64'(target), 64'h140);
    chk("t2_misdirect", 64'(misdirect), 64'd1);
    chk("t2_ready", 64'(ready_out), 64'd0);
    idle(0, 0); idle(0, 0);
    idle(1, 0);
    idle(0, 0);
    chk("t2_ready_after_ack", 64'(ready_out), 64'd1);

    // AUIPC held on the CDB while a second U-type stalls.
    cycle(1, 4, 32'h200, 32'h1000, 32'h0, 5, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cycle(1, 3, 32'h0, 32'h55, 32'h0, 6, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      chk("t3_cdb_data_hold", 64'(cdb_data), 64'h1200);
      chk("t3_cdb_rob_hold", 64'(cdb_rob), 64'd5);
    end
    cycle(1, 3, 32'h0, 32'h55, 32'h0, 6, 0, 0, 1, 0, 0, 0);
    idle(0, 1);

    // Wrapping AUIPC, then flush during a redirect with the CDB slot full.
    cycle(1, 4, 32'h7FFFFFFF, 32'h1, 32'h0, 2, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t5_wrap", 64'(cdb_data), 64'h80000000);
    cycle(1, 2, 32'h300, 32'h10, 32'h0, 3, 1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t5_redir", 64'(misdirect), 64'd1);
    chk("t5_cdb_req", 64'(cdb_req), 64'd1);
    cycle(0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("t5_flush_mis", 64'(misdirect), 64'd0);
    chk("t5_flush_cdb", 64'(cdb_req), 64'd0);

    // Fill all tags, fifth stalls until tag 2 is released.
    for (int k = 0; k < 4; k++) cycle(1, 1, 32'h400 + 32'(k), 32'h8, 32'h0, k, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h404, 32'h8, 32'h0, 4, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 32'h404, 32'h8, 32'h0, 4, 0, 0, 0, 1, 2, 0);
    cycle(1, 1, 32'h404, 32'h8, 32'h0, 4, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("t4_tag_valid", 64'(br_tag_valid), 64'd1);
    chk("t4_tag_reuse", 64'(br_tag), 64'd2);

    // Asynchronous reset while a redirect is held.
    cycle(1, 2, 32'h500, 32'h4, 32'h0, 1, 1, 0, 0, 0, 0, 0);
    idle(0, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("t6_async_mis", 64'(misdirect), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle(0, 0);
    chk("t6_ready", 64'(ready_out), 64'd1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] p, im, pr;
      p  = $urandom;
      im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
      pr = ($urandom_range(0, 1) == 1) ? p + im : $urandom;
      cycle(($urandom_range(0, 9) < 7) ? 1 : 0, int'($urandom_range(0, 4)), p, im, pr,
            int'($urandom_range(0, 7)), ($urandom_range(0, 4) != 0) ? 1 : 0,
            ($urandom_range(0, 2) == 0) ? 1 : 0, ($urandom_range(0, 4) < 2) ? 1 : 0,
            ($urandom_range(0, 9) < 3) ? 1 : 0, int'($urandom_range(0, 3)),
            ($urandom_range(0, 49) == 0) ? 1 : 0);
    end
    for (int k = 0; k < 4; k++) idle(1, 1);
    #5;
    chk("drain_seq", 64'(seq_q.size()), 64'd0);
    chk("drain_tag", 64'(tag_q.size()), 64'd0);
    chk("drain_cdb", 64'(cdb_q.size()), 64'd0);
    chk("drain_tgt", 64'(tgt_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_target_resolve_pipe.md
Name: branch_target_resolve_pipe

Overview:
Registered successor to the rename-stage early target resolver. It computes JAL and conditional-branch targets and raises a held fetch redirect on mismatch, with a ready/ack handshake. It allocates a branch tag for each conditional branch, up to DEPTH outstanding. LUI/AUIPC are executed in the same stage and presented to the CDB arbiter through a req/grant skid slot.

Parameters:
WIDTH, 32, PC/immediate/data width (signed)
ROBW, 3, ROB index width
DEPTH, 4, maximum outstanding conditional-branch tags (power of two, >=2)
PCINC, 1, sequential PC increment (word-addressed fetch)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
valid_in  in  1  rename-stage instruction valid
ready_out  out  1  block can accept valid_in this cycle
pc  in  WIDTH  instruction PC
imm_ext  in  WIDTH  sign-extended immediate
predicted_pc  in  WIDTH  fetch-predicted next PC
rob_idx  in  ROBW  ROB entry of instruction
op  in  3  0 other, 1 cond branch, 2 JAL, 3 LUI, 4 AUIPC
redirect_en  in  1  gate for misdirect (matches rename redirect)
misdirect  out  1  fetch redirect request, held until ack
target  out  WIDTH  redirect address
redirect_ack  in  1  fetch accepted redirect
seq_pc  out  WIDTH  registered pc+PCINC for ROB
seq_valid  out  1  seq_pc/seq_rob valid (1 cycle)
seq_rob  out  ROBW  ROB index for seq_pc
br_tag_valid  out  1  conditional branch allocated a tag this cycle
br_tag  out  $clog2(DEPTH)  allocated tag
br_free  in  1  commit/execute releases a tag
br_free_tag  in  $clog2(DEPTH)  tag being released
flush  in  1  pipeline flush from commit
cdb_req  out  1  U-type result pending
cdb_data  out  WIDTH  U-type result
cdb_rob  out  ROBW  U-type ROB index
cdb_grant  in  1  CDB arbiter grant

Behaviour:
- Reset (async): misdirect, seq_valid, br_tag_valid, cdb_req = 0; target, seq_pc, cdb_data = 0; tag bitmap all free; alloc pointer 0; state IDLE.
- All arithmetic is signed WIDTH-bit modulo 2^WIDTH; wrap-around is not flagged.
- Accept = valid_in & ready_out. Every output is registered, so results appear the cycle after accept.
- ready_out = 0 in any of these cases:
  - state REDIR;
  - cdb_req=1 & ~cdb_grant & op∈{3,4} (skid slot occupied);
  - op==1 & all DEPTH tags busy.
- On accept, seq_valid=1 with seq_pc=pc+PCINC and seq_rob=rob_idx, for every op.
- op 1 or 2: addr=pc+imm_ext.
  - If redirect_en & addr!=predicted_pc: next state REDIR, misdirect=1, target=addr.
  - Otherwise misdirect stays 0.
- op 1 additionally: lowest-index free tag is marked busy; br_tag_valid=1 for one cycle with br_tag=that index.
- States:
  - IDLE→REDIR on misdirect.
  - REDIR holds misdirect/target stable until redirect_ack=1 is sampled, then IDLE next cycle.
  - redirect_ack while IDLE is ignored.
- op 3: cdb_data=imm_ext. op 4: cdb_data=pc+imm_ext. Either sets cdb_req=1 with cdb_rob=rob_idx.
- cdb_req is held with data stable until cdb_grant.
  - Grant cycle with a new U-type accept: slot reloads, cdb_req stays 1.
  - Grant cycle without a new U-type accept: cdb_req=0 next cycle.
- br_free clears the tag bit next cycle. Freeing an already-free tag has no effect.
- Free and allocate in the same cycle:
  - Bitmap is updated with both operations.
  - Freed tag is not reusable until the following cycle.
- flush (synchronous, highest priority): clears cdb_req, misdirect, seq_valid, br_tag_valid and the tag bitmap; returns to IDLE; the same-cycle accept is discarded.
- Reset asserted mid-redirect or mid-CDB-hold: all state clears immediately; no ack or grant is required.

Test Plan:
- pc=0x100, imm=0x20, pred=0x120, op=1, redirect_en=1 -> next cycle misdirect=0, br_tag_valid=1, br_tag=0, seq_pc=0x101.
- pc=0x100, imm=0x40, pred=0x101, op=2 -> misdirect=1, target=0x140, ready_out=0; hold 3 cycles then redirect_ack -> misdirect=0 and ready_out=1 the cycle after.
- op=4, pc=0x200, imm=0x1000, rob=5, grant withheld 2 cycles -> cdb_req=1, cdb_data=0x1200, cdb_rob=5 stable throughout; a second U-type stalls (ready_out=0) until grant.
- Five op=1 accepts with DEPTH=4, no frees -> tags 0,1,2,3 issued, 5th stalls; br_free tag 2 -> 5th accepted next cycle with br_tag=2.
- pc=0x7FFFFFFF, imm=1, op=4 -> cdb_data=0x80000000 (wrap, no error); flush during REDIR with cdb_req=1 -> both 0 next cycle, tags all free.
- Assert reset asynchronously mid-REDIR -> misdirect=0 before next clk edge; after deassert ready_out=1.
